// File: rtl/w_stream_generator_pkg.sv
// ---------------------------------------------------------------------------
// w_stream_pkg
// Shared definitions for the w_stream_generator block.
//   - w_state_e : stream FSM states (W_IDLE, W_SHIFT, W_DONE)
//   - idx_w()   : width of bit_index for a given pattern width
//   - len_w()   : width of the len input for a given pattern width
// ---------------------------------------------------------------------------
package w_stream_pkg;

  localparam int PATTERN_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_SHIFT = 2'd1,
    W_DONE  = 2'd2
  } w_state_e;

  // A one-bit pattern still needs a one-bit index register.
  function automatic int idx_w(input int pw);
    return (pw > 1) ? $clog2(pw) : 1;
  endfunction

  function automatic int len_w(input int pw);
    return idx_w(pw) + 1;
  endfunction

endpackage

// File: rtl/w_stream_generator_if.sv
// ---------------------------------------------------------------------------
// w_stream_generator_if
// Control and serial-output bundle of the w stream generator.
//   start, stop, loop, pattern, len : driven by the controlling master
//   w, step, busy, done, bit_index  : driven by the generator (slave)
// ---------------------------------------------------------------------------
interface w_stream_generator_if
  import w_stream_pkg::*;
#(
  parameter int PATTERN_W = PATTERN_W_DEFAULT
);
  localparam int IDX_W = idx_w(PATTERN_W);
  localparam int LEN_W = len_w(PATTERN_W);

  logic                 start;
  logic                 stop;
  logic                 loop;
  logic [PATTERN_W-1:0] pattern;
  logic [LEN_W-1:0]     len;
  logic                 w;
  logic                 step;
  logic                 busy;
  logic                 done;
  logic [IDX_W-1:0]     bit_index;

  modport master (
    output start, stop, loop, pattern, len,
    input  w, step, busy, done, bit_index
  );

  modport slave (
    input  start, stop, loop, pattern, len,
    output w, step, busy, done, bit_index
  );
endinterface

// File: rtl/w_stream_generator_tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Emits a one-cycle tick every TICK_DIV cycles while enabled.
//   clock  : system clock
//   reset  : asynchronous active-high reset, counter -> 0
//   clear  : reload counter to TICK_DIV-1 (start of a new bit period)
//   enable : count down; counter holds while low
//   tick   : high when enabled and the counter is 0
// ---------------------------------------------------------------------------
module tick_divider #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == '0);

  // Auto-reload on the tick so consecutive bit periods need no extra clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = RELOAD;
    end else if (enable) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/w_stream_generator.sv
// ---------------------------------------------------------------------------
// w_stream_generator
// Latches a bit pattern and serialises it MSB-first onto w, one bit every
// TICK_DIV cycles, with a step strobe in the last cycle of each bit.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : start/stop/loop/pattern/len in; w/step/busy/done/bit_index out
// Build option: define W_STREAM_LOOP_EN to honour the loop input (pattern
// reload on completion); otherwise loop is ignored and every stream ends in
// DONE with a done pulse.
// ---------------------------------------------------------------------------
module w_stream_generator
  import w_stream_pkg::*;
#(
  parameter int PATTERN_W = 16,
  parameter int TICK_DIV  = 50_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  w_stream_generator_if.slave    bus
);
  localparam int IDX_W = idx_w(PATTERN_W);
  localparam int LEN_W = len_w(PATTERN_W);

  w_state_e             state_q, state_d;
  logic [PATTERN_W-1:0] sr_q, sr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 clear, tick, busy, last_bit;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if ((l == '0) || (l > LEN_W'(PATTERN_W))) return LEN_W'(PATTERN_W);
    return l;
  endfunction

`ifdef W_STREAM_LOOP_EN
  logic [PATTERN_W-1:0] pat_q, pat_d;
`else
  logic unused_loop;
  assign unused_loop = bus.loop;
`endif

  assign busy     = (state_q == W_SHIFT);
  assign last_bit = ({1'b0, idx_q} >= (len_q - LEN_W'(1)));

  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (busy),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    len_d   = len_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    clear   = 1'b0;
`ifdef W_STREAM_LOOP_EN
    pat_d   = pat_q;
`endif
    if (bus.stop) begin
      // Abort wins over start and over a pending step; no done pulse.
      state_d = W_IDLE;
      sr_d    = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        W_IDLE, W_DONE: begin
          if (bus.start) begin
            state_d = W_SHIFT;
            sr_d    = bus.pattern;
            len_d   = clamp_len(bus.len);
            idx_d   = '0;
            clear   = 1'b1;
`ifdef W_STREAM_LOOP_EN
            pat_d   = bus.pattern;
`endif
          end
        end
        W_SHIFT: begin
          if (tick) begin
            if (!last_bit) begin
              sr_d  = sr_q << 1;
              idx_d = idx_q + IDX_W'(1);
            end else begin
`ifdef W_STREAM_LOOP_EN
              if (bus.loop) begin
                sr_d  = pat_q;
                idx_d = '0;
              end else begin
                state_d = W_DONE;
                done_d  = 1'b1;
              end
`else
              state_d = W_DONE;
              done_d  = 1'b1;
`endif
            end
          end
        end
        default: state_d = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= W_IDLE;
      sr_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef W_STREAM_LOOP_EN
      pat_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef W_STREAM_LOOP_EN
      pat_q   <= pat_d;
`endif
    end
  end

  // w and bit_index are forced to 0 outside SHIFT so IDLE/DONE read quiet.
  assign bus.w         = busy & sr_q[PATTERN_W-1];
  assign bus.step      = tick;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.bit_index = busy ? idx_q : '0;
endmodule

// File: tb/tb_w_stream_generator.sv
// ---------------------------------------------------------------------------
// tb_w_stream_generator
// Directed bench for w_stream_generator with PATTERN_W=8, TICK_DIV=4.
// ---------------------------------------------------------------------------
module tb_w_stream_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec  = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  w_stream_generator_if #(.PATTERN_W(8)) ifc ();

  w_stream_generator #(.PATTERN_W(8), .TICK_DIV(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (ifc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.start = 1'b0; ifc.stop = 1'b0; ifc.loop = 1'b0;
    ifc.pattern = 8'h00; ifc.len = 4'd0;
    repeat (2) tick();
    vec++;
    if ({ifc.w, ifc.step, ifc.busy, ifc.done} !== 4'b0000 || ifc.bit_index !== 3'd0) begin
      miss++;
      $display("FAIL reset: w/step/busy/done=%b idx=%0d, want 0000 idx=0",
               {ifc.w, ifc.step, ifc.busy, ifc.done}, ifc.bit_index);
    end
    @(negedge clk) rst = 1'b0;
    tick();
    vec++;
    if ({ifc.w, ifc.step, ifc.busy, ifc.done} !== 4'b0000) begin
      miss++;
      $display("FAIL idle_after_reset: w/step/busy/done=%b, want 0000",
               {ifc.w, ifc.step, ifc.busy, ifc.done});
    end
  endtask

  // Start a stream with start high for one edge, check every cycle of the
  // nb bits, the done cycle and the cycle after. With perturb set, start,
  // pattern and len are changed during SHIFT and must have no effect.
  task automatic test_stream(input string nm, input logic [7:0] pat,
                             input logic [3:0] l, input int nb, input bit perturb);
    logic [3:0] exp;
    logic [2:0] eidx;
    ifc.pattern = pat; ifc.len = l; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int c = 1; c <= nb * 4; c++) begin
      if (perturb && c == 2) begin
        ifc.start = 1'b1; ifc.pattern = ~pat; ifc.len = 4'd2;
      end
      if (perturb && c == nb * 4 - 2) begin
        ifc.start = 1'b0; ifc.pattern = pat; ifc.len = l;
      end
      exp  = {pat[7 - (c - 1) / 4], ((c % 4) == 0), 1'b1, 1'b0};
      eidx = 3'((c - 1) / 4);
      vec++;
      if ({ifc.w, ifc.step, ifc.busy, ifc.done} !== exp || ifc.bit_index !== eidx) begin
        miss++;
        $display("FAIL %s cyc %0d: w/step/busy/done=%b idx=%0d, want %b idx=%0d",
                 nm, c, {ifc.w, ifc.step, ifc.busy, ifc.done}, ifc.bit_index, exp, eidx);
      end
      tick();
    end
    vec++;
    if ({ifc.w, ifc.step, ifc.busy, ifc.done} !== 4'b0001) begin
      miss++;
      $display("FAIL %s done_cycle: w/step/busy/done=%b, want 0001",
               nm, {ifc.w, ifc.step, ifc.busy, ifc.done});
    end
    tick();
    vec++;
    if ({ifc.w, ifc.step, ifc.busy, ifc.done} !== 4'b0000) begin
      miss++;
      $display("FAIL %s after_done: w/step/busy/done=%b, want 0000",
               nm, {ifc.w, ifc.step, ifc.busy, ifc.done});
    end
  endtask

  task automatic test_abort();
    ifc.pattern = 8'b1011_0010; ifc.len = 4'd8; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    repeat (9) tick();
    // cycle 10: bit 2 of the stream is on w
    vec++;
    if ({ifc.w, ifc.busy} !== 2'b11 || ifc.bit_index !== 3'd2) begin
      miss++;
      $display("FAIL abort_pre: w/busy=%b idx=%0d, want 11 idx=2",
               {ifc.w, ifc.busy}, ifc.bit_index);
    end
    ifc.stop = 1'b1; ifc.start = 1'b1;
    tick();
    // cycle 11: idle despite start having been high with stop
    vec++;
    if ({ifc.w, ifc.step, ifc.busy, ifc.done} !== 4'b0000 || ifc.bit_index !== 3'd0) begin
      miss++;
      $display("FAIL abort_idle: w/step/busy/done=%b idx=%0d, want 0000 idx=0",
               {ifc.w, ifc.step, ifc.busy, ifc.done}, ifc.bit_index);
    end
    ifc.stop = 1'b0; ifc.start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      vec++;
      if ({ifc.w, ifc.step, ifc.busy, ifc.done} !== 4'b0000) begin
        miss++;
        $display("FAIL abort_hold cyc %0d: w/step/busy/done=%b, want 0000",
                 12 + c, {ifc.w, ifc.step, ifc.busy, ifc.done});
      end
    end
  endtask

  task automatic test_reset_mid();
    ifc.pattern = 8'b1111_1111; ifc.len = 4'd8; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    repeat (12) tick();
    vec++;
    if ({ifc.w, ifc.busy} !== 2'b11) begin
      miss++;
      $display("FAIL rstmid_pre: w/busy=%b, want 11", {ifc.w, ifc.busy});
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({ifc.w, ifc.step, ifc.busy, ifc.done} !== 4'b0000 || ifc.bit_index !== 3'd0) begin
      miss++;
      $display("FAIL rstmid_async: w/step/busy/done=%b idx=%0d, want 0000 idx=0",
               {ifc.w, ifc.step, ifc.busy, ifc.done}, ifc.bit_index);
    end
    repeat (2) tick();
    @(negedge clk) rst = 1'b0;
    tick();
    vec++;
    if ({ifc.w, ifc.step, ifc.busy, ifc.done} !== 4'b0000) begin
      miss++;
      $display("FAIL rstmid_release: w/step/busy/done=%b, want 0000",
               {ifc.w, ifc.step, ifc.busy, ifc.done});
    end
    test_stream("restart", 8'b0110_1001, 4'd8, 8, 1'b0);
  endtask

`ifdef W_STREAM_LOOP_EN
  task automatic test_loop();
    logic [3:0] exp;
    ifc.pattern = 8'b1000_0000; ifc.len = 4'd2; ifc.loop = 1'b1; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 18) ifc.loop = 1'b0;
      exp = {(((c - 1) / 4) % 2 == 0), ((c % 4) == 0), 1'b1, 1'b0};
      vec++;
      if ({ifc.w, ifc.step, ifc.busy, ifc.done} !== exp) begin
        miss++;
        $display("FAIL loop cyc %0d: w/step/busy/done=%b, want %b",
                 c, {ifc.w, ifc.step, ifc.busy, ifc.done}, exp);
      end
      tick();
    end
    vec++;
    if ({ifc.w, ifc.step, ifc.busy, ifc.done} !== 4'b0001) begin
      miss++;
      $display("FAIL loop_end: w/step/busy/done=%b, want 0001",
               {ifc.w, ifc.step, ifc.busy, ifc.done});
    end
    tick();
  endtask
`else
  task automatic test_loop();
    ifc.loop = 1'b1;
    test_stream("loop_ignored", 8'b1000_0000, 4'd2, 2, 1'b0);
    ifc.loop = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stream("basic", 8'b1011_0010, 4'd8, 8, 1'b0);
    test_stream("short_len3", 8'b1011_0010, 4'd3, 3, 1'b0);
    test_stream("len0", 8'b1011_0010, 4'd0, 8, 1'b0);
    test_stream("len_over", 8'b0101_1100, 4'd15, 8, 1'b0);
    test_stream("len1", 8'b1000_0000, 4'd1, 1, 1'b0);
    test_stream("ignore_in_shift", 8'b1100_1010, 4'd8, 8, 1'b1);
    test_abort();
    test_reset_mid();
    test_loop();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/w_stream_generator.md
# w_stream_generator

Upstream stimulus stage for the sequence-detector FSM: latches a user-supplied bit pattern and serialises it MSB-first onto `w` at a fixed, divided rate. Each bit is held for `TICK_DIV` clock cycles, and a one-cycle `step` strobe marks the cycle in which the detector samples `w`. This replaces hand-toggling the `w` switch on the board and gives the bench a deterministic, repeatable input stream.

## Interface
- `PATTERN_W`, default 16: pattern register width, in bits.
- `TICK_DIV`, default 50_000_000: clock cycles per serial bit (1 Hz at 50 MHz). Legal range ≥ 2.
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  level, sampled each cycle; begins a stream when state is IDLE or DONE.
- `stop`  in  1  synchronous abort; forces IDLE on the next edge.
- `loop`  in  1  repeat the pattern on completion (only with `W_STREAM_LOOP_EN`).
- `pattern`  in  PATTERN_W  bit sequence, sent MSB first.
- `len`  in  $clog2(PATTERN_W)+1  number of bits to send; 0 or >PATTERN_W is treated as PATTERN_W.
- `w`  out  1  serial bit to the detector's `w` input.
- `step`  out  1  one-cycle strobe, high in the last cycle of each bit period.
- `busy`  out  1  high in SHIFT.
- `done`  out  1  one-cycle pulse after the final bit's `step`.
- `bit_index`  out  $clog2(PATTERN_W)  index of the bit currently on `w`, counting from 0.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE → SHIFT** when `start`=1 and `stop`=0. On this edge:
  - shift register ← `pattern`, and `len` is latched (clamped as above);
  - tick counter ← TICK_DIV-1, and `bit_index` ← 0.
- **In SHIFT:**
  - `w` = shift-register MSB.
  - The tick counter decrements each cycle.
  - `step` = 1 in the cycle the counter equals 0.
- **On a `step` cycle:**
  - If bit_index < latched_len-1: shift left by 1, bit_index+1, counter ← TICK_DIV-1.
  - Else (last bit):
    - with `loop`=1 and the macro defined: reload the latched pattern, bit_index ← 0, stay in SHIFT;
    - otherwise go to DONE and assert `done` for one cycle.
- **DONE:** `w`=0, `busy`=0. `start`=1 restarts exactly as from IDLE; otherwise DONE holds.
- **`stop`=1:** IDLE on the next edge from any state. All outputs go to 0 and no `done` pulse is issued. `stop` has priority over `start` and over `step`.
- **`start` during SHIFT:** ignored. `pattern` and `len` changes during SHIFT are also ignored, because only the latched copies are used.
- **`reset`:** immediately sets IDLE, shift register 0, counter 0, bit_index 0. Reset values: `w`=0, `step`=0, `busy`=0, `done`=0, `bit_index`=0. Asserting reset mid-stream discards the stream.

## Timing
- Latency: `start` sampled at edge t → `w`=pattern[MSB] and `busy`=1 from cycle t+1.
- The first `step` occurs at cycle t+TICK_DIV.
- Each bit is valid for exactly TICK_DIV cycles, and `step` lands in the last of them.
- `w` changes only on the edge immediately after a `step` cycle.
- `done` is high in the cycle after the final `step`, which is the first DONE cycle.
- Loop wrap: the first bit of the next pass appears on the edge after the final `step`, with no gap cycle and no `done` pulse.
- A full N-bit stream occupies N·TICK_DIV cycles of `busy`.

## Configuration
- Macro: `W_STREAM_LOOP_EN`.
- **Defined:** the `loop` input is honoured as described in Operation.
- **Undefined:** the `loop` port still exists but is ignored. Every stream terminates in DONE with a `done` pulse, and the reload path is not synthesised.

## Structure
- The shared package `w_stream_pkg` holds:
  - the state enum (`W_IDLE`, `W_SHIFT`, `W_DONE`);
  - width helper constants derived from PATTERN_W.
- One sub-module, `tick_divider`:
  - inputs: `clock`, `reset`, `clear`, `enable`;
  - output: one-cycle `tick` every TICK_DIV cycles while enabled;
  - `clear` reloads TICK_DIV-1.
- The top level contains the FSM, shift register, bit index and length latch.

## Test plan
All scenarios use TICK_DIV=4 and PATTERN_W=8.
- **Basic stream:** pattern=8'b1011_0010, len=8, start pulse at cycle 0 → `w` sequence 1,0,1,1,0,0,1,0, each held 4 cycles. `step` at cycles 4,8,…,32, `done` at cycle 33, `busy` high for cycles 1–32.
- **Short length:** len=3 with the same pattern → three bits 1,0,1, `done` after the 3rd `step`, then `w`=0.
- **len=0:** → 8 bits sent, identical to len=8.
- **Abort:** `stop` at cycle 10 → IDLE at cycle 11, all outputs 0, no `done`. A `start` held continuously through cycles 10–11 does not restart in cycle 11.
- **Reset mid-stream:** `reset` asserted between edges at cycle 13 → outputs 0 immediately (asynchronously). After release, `start` restarts from bit 0.
- **Loop** (with `W_STREAM_LOOP_EN`): loop=1, len=2, pattern MSBs 10 → `w` = 1,0,1,0,… with no `done`. Dropping loop → stream ends after the current pass's 2nd bit, and `done` pulses.
